// File: rtl/hs_sync_pkg.sv
// Shared definitions for the four-phase req/ack clock-domain-crossing handshake.
package hs_sync_pkg;

    // Fewest flops a request synchroniser may have.
    localparam int unsigned HS_MIN_SYNC_STAGES = 2;

    // Receive-side handshake state.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_VALID = 2'd1,
        ST_ACK   = 2'd2
    } hs_state_e;

endpackage : hs_sync_pkg

// File: rtl/sync_ff_chain.sv
// Multi-flop single-bit synchroniser with asynchronous active-low reset.
module sync_ff_chain #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule : sync_ff_chain

// File: rtl/hs_sync_rx.sv
// Receive side of the four-phase req/ack CDC handshake: synchronises req_a,
// captures data_a, hands it out over valid/ready, then returns ack_b.
// Optional build macro HS_RX_PARITY_EN adds par_a / sticky par_err.
module hs_sync_rx
    import hs_sync_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk_b,
    input  logic              rst_b_n,
    input  logic              req_a,
    input  logic [DATA_W-1:0] data_a,
    input  logic              out_ready,
`ifdef HS_RX_PARITY_EN
    input  logic              par_a,
    output logic              par_err,
`endif
    output logic              ack_b,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid
);

    // Refuse to elaborate with a synchroniser too short to be safe.
    if (SYNC_STAGES < HS_MIN_SYNC_STAGES) begin : g_bad_stages
        $error("hs_sync_rx: SYNC_STAGES must be at least %0d", HS_MIN_SYNC_STAGES);
    end

    hs_state_e state;
    logic      req_s;

    // req_s is the only consumer of req_a in this block.
    sync_ff_chain #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk   (clk_b),
        .rst_n (rst_b_n),
        .d     (req_a),
        .q     (req_s)
    );

    // Handshake FSM; data_a is sampled only on the capture edge out of IDLE.
    always_ff @(posedge clk_b or negedge rst_b_n) begin
        if (!rst_b_n) begin
            state     <= ST_IDLE;
            ack_b     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_s) begin
                        out_data  <= data_a;
                        out_valid <= 1'b1;
                        state     <= ST_VALID;
                    end
                end
                ST_VALID: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        ack_b     <= 1'b1;
                        state     <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    // An early req_a fall lands here with req_s already low,
                    // so ack_b pulses for a single cycle.
                    if (!req_s) begin
                        ack_b <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    ack_b     <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef HS_RX_PARITY_EN
    logic capture;
    assign capture = (state == ST_IDLE) && req_s;

    // Sticky even-parity check of the word on its capture edge.
    always_ff @(posedge clk_b or negedge rst_b_n) begin
        if (!rst_b_n) begin
            par_err <= 1'b0;
        end else if (capture && (^{data_a, par_a})) begin
            par_err <= 1'b1;
        end
    end
`endif

endmodule : hs_sync_rx
